// File: rtl/hazard_scheduler.sv
// Pipeline hazard scheduler: tracks in-flight register writers in EX/MEM and
// picks one of RUN / DATA_STALL / MEM_WAIT / FLUSH each cycle.
module hazard_scheduler (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ifid_valid,
  input  logic [4:0]  ifid_rs1,
  input  logic [4:0]  ifid_rs2,
  input  logic        id_regwrite,
  input  logic [4:0]  id_rd,
  input  logic        ex_branch_taken,
  input  logic        mem_busy,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pipe_we,
  output logic [1:0]  ctrl_state,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    ACT_RUN        = 2'd0,
    ACT_DATA_STALL = 2'd1,
    ACT_MEM_WAIT   = 2'd2,
    ACT_FLUSH      = 2'd3
  } action_e;

  logic          ex_valid_q, ex_valid_d;
  logic [4:0]    ex_rd_q, ex_rd_d;
  logic          mem_valid_q, mem_valid_d;
  logic [4:0]    mem_rd_q, mem_rd_d;
  action_e       ctrl_state_q, ctrl_state_d;
  logic [15:0]   stall_cycles_q, stall_cycles_d;
  action_e       action_s;
  logic          hazard_s;

  // x0 is hardwired, so a zero source never depends on an in-flight writer.
  function automatic logic src_hazard(
    input logic [4:0] rs,
    input logic       v_ex,
    input logic [4:0] rd_ex,
    input logic       v_mem,
    input logic [4:0] rd_mem
  );
    return (rs != 5'd0) && ((v_ex && (rd_ex == rs)) || (v_mem && (rd_mem == rs)));
  endfunction

  // Hazard detection and action priority
  always_comb begin
    hazard_s = ifid_valid &&
               (src_hazard(ifid_rs1, ex_valid_q, ex_rd_q, mem_valid_q, mem_rd_q) ||
                src_hazard(ifid_rs2, ex_valid_q, ex_rd_q, mem_valid_q, mem_rd_q));
    if (mem_busy) begin
      action_s = ACT_MEM_WAIT;
    end else if (ex_branch_taken) begin
      action_s = ACT_FLUSH;
    end else if (hazard_s) begin
      action_s = ACT_DATA_STALL;
    end else begin
      action_s = ACT_RUN;
    end
  end

  // Pipeline control decode
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_we     = 1'b1;
    case (action_s)
      ACT_RUN: begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        pipe_we     = 1'b1;
      end
      ACT_DATA_STALL: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
      end
      ACT_MEM_WAIT: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        pipe_we     = 1'b0;
      end
      ACT_FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      default: begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        pipe_we     = 1'b1;
      end
    endcase
  end

  // Scoreboard advance and status counters
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_rd_d        = ex_rd_q;
    mem_valid_d    = mem_valid_q;
    mem_rd_d       = mem_rd_q;
    ctrl_state_d   = action_s;
    stall_cycles_d = stall_cycles_q;
    if (action_s != ACT_MEM_WAIT) begin
      mem_valid_d = ex_valid_q;
      mem_rd_d    = ex_rd_q;
      // Only an instruction actually leaving ID becomes a tracked writer.
      if ((action_s == ACT_RUN) && ifid_valid && id_regwrite && (id_rd != 5'd0)) begin
        ex_valid_d = 1'b1;
        ex_rd_d    = id_rd;
      end else begin
        ex_valid_d = 1'b0;
        ex_rd_d    = 5'd0;
      end
    end else begin
      mem_valid_d = mem_valid_q;
      mem_rd_d    = mem_rd_q;
    end
    if ((action_s != ACT_RUN) && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_valid_q     <= 1'b0;
      ex_rd_q        <= 5'd0;
      mem_valid_q    <= 1'b0;
      mem_rd_q       <= 5'd0;
      ctrl_state_q   <= ACT_RUN;
      stall_cycles_q <= 16'd0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rd_q        <= ex_rd_d;
      mem_valid_q    <= mem_valid_d;
      mem_rd_q       <= mem_rd_d;
      ctrl_state_q   <= ctrl_state_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign ctrl_state   = ctrl_state_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Scoreboard bench for hazard_scheduler: directed per-cycle vectors push the
// hand-chosen action's expected outputs; a negedge monitor pops and compares.
module tb_hazard_scheduler;

  localparam logic [1:0] R = 2'd0;
  localparam logic [1:0] D = 2'd1;
  localparam logic [1:0] M = 2'd2;
  localparam logic [1:0] F = 2'd3;

  typedef logic [22:0] rec_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ifid_valid;
  logic [4:0]  ifid_rs1, ifid_rs2, id_rd;
  logic        id_regwrite, ex_branch_taken, mem_busy;
  logic        pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_cycles;

  rec_t        exp_q[$];
  rec_t        mon_e, mon_a;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [1:0]  m_prev;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  hazard_scheduler dut (
    .clk(clk), .rstn(rstn), .ifid_valid(ifid_valid), .ifid_rs1(ifid_rs1),
    .ifid_rs2(ifid_rs2), .id_regwrite(id_regwrite), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .pc_we(pc_we),
    .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .pipe_we(pipe_we), .ctrl_state(ctrl_state), .stall_cycles(stall_cycles)
  );

  // Expected enables per action, plus the previous action and the stall count.
  function automatic rec_t exp_rec(input logic [1:0] act, input logic [1:0] prev,
                                   input logic [15:0] cnt);
    logic [4:0] en;
    case (act)
      R:       en = 5'b11001;
      D:       en = 5'b00011;
      M:       en = 5'b00000;
      F:       en = 5'b11111;
      default: en = 5'b11001;
    endcase
    return {en, prev, cnt};
  endfunction

  task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic rw, input logic [4:0] rd, input logic br,
                      input logic busy, input logic [1:0] act);
    @(posedge clk);
    #1;
    ifid_valid = v; ifid_rs1 = rs1; ifid_rs2 = rs2;
    id_regwrite = rw; id_rd = rd; ex_branch_taken = br; mem_busy = busy;
    exp_q.push_back(exp_rec(act, m_prev, m_cnt));
    m_prev = act;
    if (act != R && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
  endtask

  task automatic idle(input logic [1:0] act);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, act);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we, ctrl_state, stall_cycles};
      n_tests++;
      if (mon_a !== mon_e) begin
        n_fail++;
        $display("FAIL cycle_out @%0t: got %h expected %h", $time, mon_a, mon_e);
      end
    end
  end

  initial begin
    rstn = 1'b0; ifid_valid = 1'b0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0;
    id_regwrite = 1'b0; id_rd = 5'd0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
    m_prev = R; m_cnt = 16'd0;
    #3;
    chk("reset_enables", {27'd0, pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we}, 32'h19);
    chk("reset_ctrl_state", {30'd0, ctrl_state}, 32'd0);
    chk("reset_stall_cycles", {16'd0, stall_cycles}, 32'd0);
    mem_busy = 1'b1;
    #1;
    chk("reset_busy_enables", {27'd0, pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we}, 32'h0);
    mem_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Writer x5 then reader rs1=5: two stall cycles
    step(1'b1, 5'd0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, R);
    step(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, D);
    step(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, D);
    step(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, R);
    idle(R);
    chk("two_stall_count", {16'd0, stall_cycles}, 32'd2);

    // Writer x5, independent, reader rs2=5: one stall cycle
    step(1'b1, 5'd0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, R);
    step(1'b1, 5'd1, 5'd2, 1'b1, 5'd6, 1'b0, 1'b0, R);
    step(1'b1, 5'd0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, D);
    step(1'b1, 5'd0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, R);
    idle(R);
    idle(R);

    // Writer x0 is never tracked
    step(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, R);
    step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, R);
    chk("x0_ex_valid", {31'd0, dut.ex_valid_q}, 32'd0);
    idle(R);

    // Branch coinciding with a hazard resolves as FLUSH
    step(1'b1, 5'd0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0, R);
    step(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, F);
    idle(R);
    idle(R);

    // mem_busy freezes a stall after its first cycle
    step(1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, R);
    step(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, D);
    step(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, M);
    step(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, M);
    step(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, M);
    step(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, D);
    step(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, R);
    idle(R);

    // MEM_WAIT beats FLUSH; a writer seen during MEM_WAIT is not captured
    step(1'b1, 5'd0, 5'd0, 1'b1, 5'd3, 1'b1, 1'b1, M);
    step(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, R);
    idle(R);

    // Reset asserted mid-stall ends the stall immediately
    step(1'b1, 5'd0, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, R);
    step(1'b1, 5'd0, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, D);
    @(posedge clk);
    #1;
    chk("midstall_bubble", {31'd0, idex_bubble}, 32'd1);
    chk("midstall_ctrl_state", {30'd0, ctrl_state}, 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    chk("midstall_reset_enables", {27'd0, pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we}, 32'h19);
    chk("midstall_reset_ctrl", {30'd0, ctrl_state}, 32'd0);
    chk("midstall_reset_count", {16'd0, stall_cycles}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    m_prev = R; m_cnt = 16'd0;
    idle(R);
    idle(R);

    // Saturate the stall counter with forced MEM_WAIT cycles
    for (int i = 0; i < 65540; i++) begin
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, M);
    end
    @(posedge clk);
    #1;
    chk("sat_count", {16'd0, stall_cycles}, 32'h0000FFFF);
    chk("sat_ctrl_state", {30'd0, ctrl_state}, 32'd2);
    #1;
    rstn = 1'b0;
    #1;
    chk("sat_async_reset", {16'd0, stall_cycles}, 32'd0);
    chk("sat_async_ctrl", {30'd0, ctrl_state}, 32'd0);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scheduler.md
HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rstn  in  1  asynchronous active-low reset.
REQ-004 ifid_valid  in  1  IF/ID holds a real instruction.
REQ-005 ifid_rs1, ifid_rs2  in  5 each  source registers of the instruction in ID.
REQ-006 id_regwrite  in  1  instruction in ID writes a register.
REQ-007 id_rd  in  5  destination register of the instruction in ID.
REQ-008 ex_branch_taken  in  1  taken branch or jump resolved in EX this cycle.
REQ-009 mem_busy  in  1  data memory access not yet complete.
REQ-010 pc_we  out  1  PC update enable.
REQ-011 ifid_we  out  1  IF/ID register load enable.
REQ-012 ifid_flush  out  1  clear IF/ID to NOP.
REQ-013 idex_bubble  out  1  load NOP into ID/EX.
REQ-014 pipe_we  out  1  load enable for ID/EX, EX/MEM and MEM/WB.
REQ-015 ctrl_state  out  2  registered action of the previous cycle: 0 RUN, 1 DATA_STALL, 2 MEM_WAIT, 3 FLUSH.
REQ-016 stall_cycles  out  16  saturating count of non-RUN cycles.

Function
REQ-017 The block SHALL keep a 2-entry scoreboard, EX and MEM, each entry holding {valid, rd[4:0]}, that tracks the destinations of in-flight writers.
REQ-018 The register file is write-before-read, so the block SHALL NOT track the WB stage.
REQ-019 A data hazard SHALL exist when all of the following hold:
- ifid_valid=1;
- ifid_rs1 or ifid_rs2 is non-zero;
- that source register equals rd of a valid EX or MEM entry.
REQ-020 Register x0 SHALL never cause a hazard.
REQ-021 Actions SHALL be prioritised MEM_WAIT > FLUSH > DATA_STALL > RUN, and the outputs SHALL be combinational from the inputs and the scoreboard.
REQ-022 MEM_WAIT (mem_busy=1) SHALL drive pc_we=0, ifid_we=0, pipe_we=0, ifid_flush=0 and idex_bubble=0, and the scoreboard SHALL hold.
REQ-023 FLUSH (ex_branch_taken=1) SHALL drive:
- pc_we=1, ifid_we=1, pipe_we=1;
- ifid_flush=1, idex_bubble=1.
REQ-024 DATA_STALL SHALL drive pc_we=0, ifid_we=0, pipe_we=1, idex_bubble=1 and ifid_flush=0.
REQ-025 RUN SHALL drive pc_we=1, ifid_we=1, pipe_we=1, ifid_flush=0 and idex_bubble=0.
REQ-026 On each clock edge when the action is not MEM_WAIT, the scoreboard SHALL advance:
- MEM <= EX;
- EX <= {1, id_rd} only in RUN with ifid_valid=1, id_regwrite=1 and id_rd!=0;
- otherwise EX <= {0, 0}.
REQ-027 A hazard SHALL therefore last at most 2 consecutive cycles when mem_busy=0.
REQ-028 On every clock edge, ctrl_state SHALL load the code of the current action.
REQ-029 On every clock edge, stall_cycles SHALL increment by 1 when the action is not RUN and saturate at 16'hFFFF without wrapping.
REQ-030 A branch coinciding with a hazard SHALL resolve as FLUSH, and the hazard SHALL be discarded because the flushed instruction is killed.
REQ-031 mem_busy asserted during a DATA_STALL SHALL freeze the stall, and the hazard SHALL resume evaluation once mem_busy drops.

Reset
REQ-032 While rstn=0 (asynchronous), the following SHALL be cleared:
- both scoreboard entries to {0, 0};
- ctrl_state to 0;
- stall_cycles to 0.
REQ-033 During reset, the combinational outputs SHALL reflect the empty scoreboard: pc_we=1, ifid_we=1, pipe_we=1, ifid_flush=0 and idex_bubble=0, unless mem_busy or ex_branch_taken is asserted.
REQ-034 A reset asserted mid-stall SHALL end the stall immediately, because the scoreboard is empty.

Verification
REQ-035 Writer to x5, followed by a reader of rs1=5 -> 2 DATA_STALL cycles (pc_we=0, idex_bubble=1), then RUN; stall_cycles=2.
REQ-036 Writer to x5, one independent instruction, then a reader of rs2=5 -> exactly 1 DATA_STALL cycle.
REQ-037 Writer to x0, then a reader of rs1=0 -> no stall; scoreboard EX.valid=0.
REQ-038 Hazard present and ex_branch_taken=1 in the same cycle -> ifid_flush=1, idex_bubble=1, pc_we=1, ctrl_state=3 next cycle.
REQ-039 mem_busy=1 for 3 cycles during the first DATA_STALL cycle -> all enables 0 and the scoreboard frozen for those 3 cycles, then 1 further DATA_STALL cycle; stall_cycles=5.
REQ-040 stall_cycles preset near saturation by 65540 forced non-RUN cycles -> value holds at 16'hFFFF; rstn pulsed low -> value 0 with no clock edge.
